// File: rtl/dmem_responder.sv
// dmem_responder: single-line write-back buffer serving core loads/stores over a 4-beat 64-bit backing port
module dmem_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic [3:0]  i_dmem_rmask,
  input  logic [3:0]  i_dmem_wmask,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_resp,
  output logic [31:0] o_bmem_addr,
  output logic        o_bmem_read,
  output logic        o_bmem_write,
  output logic [63:0] o_bmem_wdata,
  input  logic        i_bmem_ready,
  input  logic [63:0] i_bmem_rdata,
  input  logic        i_bmem_rvalid
);
  typedef enum logic [2:0] {IDLE, RESP, WB, RD_REQ, FILL} state_t;
  state_t r_state, w_next;
  logic [255:0] r_line;
  logic [26:0]  r_tag;
  logic         r_valid, r_dirty;
  logic [1:0]   r_cnt;
  logic [31:0]  r_rdata;
  logic         w_req, w_wr, w_hit;
  logic [31:0]  w_word, w_merge;
  assign w_req = (|i_dmem_rmask) | (|i_dmem_wmask);
  assign w_wr = |i_dmem_wmask;
  assign w_hit = r_valid && (r_tag == i_dmem_addr[31:5]);
  assign w_word = r_line[{i_dmem_addr[4:2], 5'b0} +: 32];
  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign w_merge[8*b +: 8] = i_dmem_wmask[b] ? i_dmem_wdata[8*b +: 8] : w_word[8*b +: 8];
  end
  assign o_dmem_resp = r_state == RESP;
  assign o_dmem_rdata = r_rdata;
  always_comb begin
    w_next = r_state;
    o_bmem_read = 1'b0;
    o_bmem_write = 1'b0;
    o_bmem_addr = 32'd0;
    o_bmem_wdata = 64'd0;
    case (r_state)
      IDLE: if (w_req) w_next = w_hit ? RESP : (r_valid && r_dirty) ? WB : RD_REQ;
      RESP: w_next = IDLE;
      WB: begin
        o_bmem_write = 1'b1;
        o_bmem_addr = {r_tag, 5'b0};
        o_bmem_wdata = r_line[{r_cnt, 6'b0} +: 64];
        if (i_bmem_ready && r_cnt == 2'd3) w_next = RD_REQ;
      end
      RD_REQ: begin
        o_bmem_read = 1'b1;
        o_bmem_addr = {i_dmem_addr[31:5], 5'b0};
        if (i_bmem_ready) w_next = FILL;
      end
      FILL: if (i_bmem_rvalid && r_cnt == 2'd3) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_line <= '0;
      r_tag <= '0;
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
      r_cnt <= 2'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_req && w_hit) begin
          r_rdata <= w_wr ? 32'd0 : w_word;
          if (w_wr) begin
            r_line[{i_dmem_addr[4:2], 5'b0} +: 32] <= w_merge;
            r_dirty <= 1'b1;
          end
        end else if (w_req) r_cnt <= 2'd0;
        WB: if (i_bmem_ready) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_dirty <= 1'b0;
        end
        RD_REQ: if (i_bmem_ready) r_cnt <= 2'd0;
        FILL: if (i_bmem_rvalid) begin
          r_line[{r_cnt, 6'b0} +: 64] <= i_bmem_rdata;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_tag <= i_dmem_addr[31:5];
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench acting as core and backing memory
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_dmem_addr = 32'd0;
  logic [3:0]  i_dmem_rmask = 4'd0;
  logic [3:0]  i_dmem_wmask = 4'd0;
  logic [31:0] i_dmem_wdata = 32'd0;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_resp;
  logic [31:0] o_bmem_addr;
  logic        o_bmem_read;
  logic        o_bmem_write;
  logic [63:0] o_bmem_wdata;
  logic        i_bmem_ready = 1'b1;
  logic [63:0] i_bmem_rdata = 64'd0;
  logic        i_bmem_rvalid = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] q[$];
  int c;

  dmem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .i_dmem_addr(i_dmem_addr), .i_dmem_rmask(i_dmem_rmask), .i_dmem_wmask(i_dmem_wmask),
    .i_dmem_wdata(i_dmem_wdata), .o_dmem_rdata(o_dmem_rdata), .o_dmem_resp(o_dmem_resp),
    .o_bmem_addr(o_bmem_addr), .o_bmem_read(o_bmem_read), .o_bmem_write(o_bmem_write),
    .o_bmem_wdata(o_bmem_wdata), .i_bmem_ready(i_bmem_ready), .i_bmem_rdata(i_bmem_rdata),
    .i_bmem_rvalid(i_bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_dmem_resp) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp with rdata %h want no resp at %0t", o_dmem_rdata, $time);
      end else chk("resp_rdata", 64'(o_dmem_rdata), 64'(q.pop_front()));
    end
  end

  task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input logic [31:0] exp);
    q.push_back(exp);
    i_dmem_addr = a;
    i_dmem_rmask = rm;
    i_dmem_wmask = wm;
    i_dmem_wdata = wd;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    @(posedge clk);
    do begin @(negedge clk); cyc++; end while (!o_dmem_resp && cyc < 40);
    if (!o_dmem_resp) begin
      n_vec++;
      n_bad++;
      $display("FAIL resp_timeout: got no resp want resp within 40 cycles");
    end
    @(posedge clk); #1;
    i_dmem_rmask = 4'd0;
    i_dmem_wmask = 4'd0;
  endtask

  task automatic idle_chk(input int n, input logic [31:0] rd);
    repeat (n) begin
      @(negedge clk);
      chk("idle_bmem", 64'({o_bmem_read, o_bmem_write}), 64'd0);
      chk("rdata_hold", 64'(o_dmem_rdata), 64'(rd));
      @(posedge clk); #1;
    end
  endtask

  task automatic serve_wb(input logic [31:0] a, input logic [255:0] b, input int stall);
    int t = 0;
    do begin @(negedge clk); t++; end while (!o_bmem_write && t < 40);
    chk("wb_write", 64'(o_bmem_write), 64'd1);
    if (stall > 0) i_bmem_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("wb_hold_ctl", 64'({o_bmem_read, o_bmem_write, o_dmem_resp}), 64'b010);
      chk("wb_hold_data", o_bmem_wdata, b[63:0]);
    end
    i_bmem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("wb_addr", 64'(o_bmem_addr), 64'(a));
      chk("wb_beat", o_bmem_wdata, b[64*k +: 64]);
      chk("wb_noread", 64'(o_bmem_read), 64'd0);
      if (k < 3) @(negedge clk);
    end
  endtask

  task automatic serve_fill(input logic [31:0] a, input logic [255:0] b, input int stall, input bit gap);
    int t = 0;
    do begin @(negedge clk); t++; end while (!o_bmem_read && t < 40);
    chk("rd_req", 64'(o_bmem_read), 64'd1);
    chk("rd_addr", 64'(o_bmem_addr), 64'(a));
    chk("rd_nowrite", 64'(o_bmem_write), 64'd0);
    if (stall > 0) i_bmem_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      i_bmem_rvalid = 1'b1;
      i_bmem_rdata = 64'hBAD0BAD0_BAD0BAD0;
      @(negedge clk);
      chk("rd_hold_ctl", 64'({o_bmem_read, o_bmem_write, o_dmem_resp}), 64'b100);
      chk("rd_hold_addr", 64'(o_bmem_addr), 64'(a));
    end
    i_bmem_rvalid = 1'b0;
    i_bmem_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      i_bmem_rvalid = 1'b1;
      i_bmem_rdata = b[64*k +: 64];
      @(posedge clk);
      if (gap && k == 2) begin
        #1;
        i_bmem_rvalid = 1'b0;
        @(posedge clk);
      end
    end
    #1;
    i_bmem_rvalid = 1'b0;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_resp", 64'(o_dmem_resp), 64'd0);
    chk("rst_rdata", 64'(o_dmem_rdata), 64'd0);
    chk("rst_bmem_ctl", 64'({o_bmem_read, o_bmem_write}), 64'd0);
    chk("rst_bmem_addr", 64'(o_bmem_addr), 64'd0);
    chk("rst_bmem_wdata", o_bmem_wdata, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h1004, 4'hF, 4'h0, 32'd0, 32'h11111111);
    serve_fill(32'h1000, {64'h77777777_66666666, 64'h55555555_44444444,
                          64'h33333333_22222222, 64'h11111111_00000000}, 0, 1'b1);
    wait_resp(c);
    idle_chk(3, 32'h11111111);

    issue(32'h1004, 4'h0, 4'b0100, 32'h00AB0000, 32'd0);
    wait_resp(c);
    chk("store_hit_lat", 64'(c), 64'd1);
    idle_chk(1, 32'd0);
    issue(32'h1004, 4'hF, 4'h0, 32'd0, 32'h11AB1111);
    wait_resp(c);
    chk("load_hit_lat", 64'(c), 64'd1);
    idle_chk(2, 32'h11AB1111);

    issue(32'h2008, 4'hF, 4'h0, 32'd0, 32'h0000000A);
    serve_wb(32'h1000, {64'h77777777_66666666, 64'h55555555_44444444,
                        64'h33333333_22222222, 64'h11AB1111_00000000}, 5);
    serve_fill(32'h2000, {64'h0000000F_0000000E, 64'h0000000D_0000000C,
                          64'h0000000B_0000000A, 64'h00000009_00000008}, 5, 1'b0);
    wait_resp(c);
    idle_chk(2, 32'h0000000A);
    issue(32'h200C, 4'b0001, 4'h0, 32'd0, 32'h0000000B);
    wait_resp(c);
    chk("partial_load_lat", 64'(c), 64'd1);
    idle_chk(1, 32'h0000000B);

    i_dmem_addr = 32'h3010;
    i_dmem_rmask = 4'hF;
    c = 0;
    do begin @(negedge clk); c++; end while (!o_bmem_read && c < 40);
    chk("mid_rd_req", 64'(o_bmem_read), 64'd1);
    @(posedge clk);
    #1 i_bmem_rvalid = 1'b1;
    i_bmem_rdata = 64'hDEADBEEF_DEADBEEF;
    @(posedge clk);
    #1 i_bmem_rdata = 64'hFEEDFACE_FEEDFACE;
    @(posedge clk);
    #3 rst_n = 1'b0;
    i_bmem_rvalid = 1'b0;
    #1;
    chk("mid_rst_rdata", 64'(o_dmem_rdata), 64'd0);
    chk("mid_rst_ctl", 64'({o_dmem_resp, o_bmem_read, o_bmem_write}), 64'd0);
    chk("mid_rst_addr", 64'(o_bmem_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'h3010, 4'hF, 4'h0, 32'd0, 32'hA4A4A4A4);
    serve_fill(32'h3000, {64'hA7A7A7A7_A6A6A6A6, 64'hA5A5A5A5_A4A4A4A4,
                          64'hA3A3A3A3_A2A2A2A2, 64'hA1A1A1A1_A0A0A0A0}, 0, 1'b0);
    wait_resp(c);
    idle_chk(1, 32'hA4A4A4A4);
    issue(32'h301C, 4'hF, 4'h0, 32'd0, 32'hA7A7A7A7);
    wait_resp(c);
    idle_chk(1, 32'hA7A7A7A7);
    issue(32'h3018, 4'hF, 4'b1001, 32'h12000034, 32'd0);
    wait_resp(c);
    chk("both_mask_lat", 64'(c), 64'd1);
    idle_chk(1, 32'd0);
    issue(32'h3018, 4'hF, 4'h0, 32'd0, 32'h12A6A634);
    wait_resp(c);
    idle_chk(3, 32'h12A6A634);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
